alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Execute-stage consumer of the 3-bit `aluop` code produced by the main decoder. Combines `aluop` with `func3`/`func7` to select the ALU operation, computes the result, resolves branch conditions, and holds the outcome in a single valid/ready pipeline register for the memory/writeback stage. It also flags illegal encodings and counts retired operations.

## Interface
- `XLEN`, 32: datapath width. Shift amount is `b[$clog2(XLEN)-1:0]`.
- `clk_i` input 1: the block's single clock.
- `rst_i` input 1: reset, synchronous and active-high.
- `in_valid_i` input 1: an operation is present on the inputs.
- `in_ready_o` output 1: the stage accepts the operation this cycle.
- `aluop_i` input 3: 000 R-type, 001 I-type, 010 branch, 011 JAL/JALR, 100 load, 101 store, 110 LUI, 111 invalid.
- `func3_i` input 3: instruction func3.
- `func7_i` input 7: instruction func7; only bit 5 is used.
- `a_i` input XLEN: operand A (rs1).
- `b_i` input XLEN: operand B (rs2 or immediate; LUI immediate is already shifted).
- `pc_i` input XLEN: PC of the operation.
- `flush_i` input 1: kill the held entry and refuse input this cycle.
- `out_valid_o` output 1: the pipeline register holds a result.
- `out_ready_i` input 1: downstream consumes the result.
- `result_o` output XLEN: registered result.
- `branch_taken_o` output 1: registered branch decision (branch ops only).
- `illegal_o` output 1: registered illegal-encoding flag.
- `retired_o` output 32: count of completed output handshakes.

## Operation
- Accept condition: `accept = in_valid_i && in_ready_o`.
- `in_ready_o = !flush_i && (!out_valid_o || out_ready_i)`. This is combinational and has no bubble on back-to-back transfers.
- aluop 000, selected by func3:
  - 000: ADD, or SUB when func7[5] is set.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when func7[5] is set.
  - 110: OR.
  - 111: AND.
- aluop 001: same as 000, except func3=000 is always ADD. func7[5] is honoured only for func3=101.
- aluop 100 and 101: `result = a + b`.
- aluop 110: `result = b`.
- aluop 011: `result = pc + 4` (link address).
- aluop 010: `result = 0`, and `branch_taken` is set by func3:
  - 000 EQ, 001 NE.
  - 100 LT, 101 GE (signed).
  - 110 LTU, 111 GEU.
  - 010 and 011 are illegal.
- Illegal encodings: aluop 111, or branch with func3 010/011. These give `illegal = 1`, `result = 0`, `branch_taken = 0`.
- `branch_taken = 0` for every non-branch op.
- Arithmetic wraps modulo 2^XLEN. SRA replicates a[XLEN-1]. SLT/SLTU produce 0 or 1, zero-extended.
- Register update, in priority order:
  1. `rst_i`
  2. `flush_i`: `out_valid_o <= 0`.
  3. `accept`: load result, flags, `out_valid_o <= 1`.
  4. `out_ready_i`: `out_valid_o <= 0`.
  5. Otherwise hold.
- While `out_valid_o && !out_ready_i`, `result_o`, `branch_taken_o` and `illegal_o` are stable.
- `retired_o` increments when `out_valid_o && out_ready_i && !flush_i`. It wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values: `out_valid_o` 0, `result_o` 0, `branch_taken_o` 0, `illegal_o` 0, `retired_o` 0.
- `in_ready_o` is 1 in the cycle after reset, unless `flush_i` is asserted.
- Latency is one cycle: an op accepted at edge N is presented from edge N onward (valid in cycle N+1). Throughput is one op per cycle when `out_ready_i` stays high.
- Output handshake and new accept in the same cycle: the new op replaces the old one and `retired_o` increments once.
- Flush while holding an entry: the entry is discarded and not counted. Input is refused that cycle, so no op is lost silently.
- Reset mid-stall: the held entry is dropped and the counter clears. Reset overrides flush and accept.
- Illegal ops still flow through the handshake and are counted.

## Test plan
- Reset, then R-type SUB (aluop 000, func3 000, func7 0x20), a=5, b=7: `result_o = 0xFFFF_FFFE` one cycle later, `retired_o` goes 0 to 1 on handshake.
- I-type SRAI (001, func3 101, func7 0x20), a=0x8000_0000, b=4: result 0xF800_0000. Same inputs with func7 0x00: result 0x0800_0000.
- Branch BLTU (010, func3 110), a=1, b=0xFFFF_FFFF: `branch_taken_o = 1`, result 0. BLT with the same operands: taken = 0. func3 010: `illegal_o = 1`.
- Back-pressure: hold `out_ready_i = 0` for 3 cycles with `in_valid_i = 1`. `in_ready_o = 0`, outputs stable, counter unchanged. Release: one handshake per cycle, no bubble.
- Flush while holding JAL (011, pc=0x100, result 0x104) with `out_ready_i = 0`: next cycle `out_valid_o = 0`, `retired_o` unchanged, `in_ready_o = 0` during the flush cycle.
- Counter wrap: preload by 0xFFFF_FFFF handshakes (or force), one more handshake gives `retired_o = 0`. Assert `rst_i` mid-stall: all outputs return to reset values next edge.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: decodes aluop/func3/func7, resolves branches and
// holds one result in a valid/ready register for the next stage.
module alu_exec_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      aluop_i,
  input  logic [2:0]      func3_i,
  input  logic [6:0]      func7_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            branch_taken_o,
  output logic            illegal_o,
  output logic [31:0]     retired_o
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_R     = 3'b000,
    OP_I     = 3'b001,
    OP_BR    = 3'b010,
    OP_JAL   = 3'b011,
    OP_LOAD  = 3'b100,
    OP_STORE = 3'b101,
    OP_LUI   = 3'b110,
    OP_BAD   = 3'b111
  } aluop_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            taken;
    logic            illegal;
  } ex_res_t;

  aluop_e          op;
  logic [SHW-1:0]  shamt;
  logic            alt;
  logic            sub_en;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic [XLEN-1:0] arith;
  ex_res_t         ex;
  logic            accept;
  logic            unused_f7;

  assign op        = aluop_e'(aluop_i);
  assign shamt     = b_i[SHW-1:0];
  assign alt       = func7_i[5];
  assign unused_f7 = ^{func7_i[6], func7_i[4:0]};

  assign lt_s = $signed(a_i) < $signed(b_i);
  assign lt_u = a_i < b_i;
  assign eq   = a_i == b_i;

  // SUB only exists for R-type; I-type func3=000 is always ADDI
  assign sub_en = (op == OP_R) && alt;

  always_comb begin
    arith = '0;
    unique case (func3_i)
      3'b000: arith = sub_en ? a_i - b_i : a_i + b_i;
      3'b001: arith = a_i << shamt;
      3'b010: arith = {{(XLEN-1){1'b0}}, lt_s};
      3'b011: arith = {{(XLEN-1){1'b0}}, lt_u};
      3'b100: arith = a_i ^ b_i;
      3'b101: arith = alt ? XLEN'($signed(a_i) >>> shamt)
                          : a_i >> shamt;
      3'b110: arith = a_i | b_i;
      3'b111: arith = a_i & b_i;
      default: arith = '0;
    endcase
  end

  always_comb begin
    ex = '0;
    unique case (op)
      OP_R, OP_I: ex.result = arith;
      OP_BR: begin
        unique case (func3_i)
          3'b000: ex.taken = eq;
          3'b001: ex.taken = !eq;
          3'b100: ex.taken = lt_s;
          3'b101: ex.taken = !lt_s;
          3'b110: ex.taken = lt_u;
          3'b111: ex.taken = !lt_u;
          default: ex.illegal = 1'b1;
        endcase
      end
      OP_JAL:            ex.result = pc_i + XLEN'(4);
      OP_LOAD, OP_STORE: ex.result = a_i + b_i;
      OP_LUI:            ex.result = b_i;
      OP_BAD:            ex.illegal = 1'b1;
      default:           ex.illegal = 1'b1;
    endcase
  end

  assign in_ready_o = !flush_i && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o    <= 1'b0;
      result_o       <= '0;
      branch_taken_o <= 1'b0;
      illegal_o      <= 1'b0;
      retired_o      <= '0;
    end else begin
      if (out_valid_o && out_ready_i && !flush_i)
        retired_o <= retired_o + 32'd1;
      if (flush_i) begin
        out_valid_o <= 1'b0;
      end else if (accept) begin
        out_valid_o    <= 1'b1;
        result_o       <= ex.result;
        branch_taken_o <= ex.taken;
        illegal_o      <= ex.illegal;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: vector table plus handshake,
// flush, counter-wrap and reset corner sequences.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  aluop;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        taken;
  logic        illegal;
  logic [31:0] retired;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  alu_exec_stage #(.XLEN(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .aluop_i        (aluop),
    .func3_i        (func3),
    .func7_i        (func7),
    .a_i            (a),
    .b_i            (b),
    .pc_i           (pc),
    .flush_i        (flush),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .result_o       (result),
    .branch_taken_o (taken),
    .illegal_o      (illegal),
    .retired_o      (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] res;
    logic        tk;
    logic        il;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] vpc);
    aluop = op; func3 = f3; func7 = f7;
    a = va; b = vb; pc = vpc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] last;
    vt.push_back('{"sub",   3'b000, 3'b000, 7'h20, 32'd5, 32'd7, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0});
    vt.push_back('{"srai",  3'b001, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 32'h0, 32'hF800_0000, 1'b0, 1'b0});
    vt.push_back('{"srli",  3'b001, 3'b101, 7'h00, 32'h8000_0000, 32'd4, 32'h0, 32'h0800_0000, 1'b0, 1'b0});
    vt.push_back('{"addi7", 3'b001, 3'b000, 7'h20, 32'd5, 32'd7, 32'h0, 32'd12, 1'b0, 1'b0});
    vt.push_back('{"bltu",  3'b010, 3'b110, 7'h00, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0});
    vt.push_back('{"blt",   3'b010, 3'b100, 7'h00, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0});
    vt.push_back('{"bge",   3'b010, 3'b101, 7'h00, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0});
    vt.push_back('{"bgeu",  3'b010, 3'b111, 7'h00, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0});
    vt.push_back('{"beq",   3'b010, 3'b000, 7'h00, 32'd9, 32'd9, 32'h0, 32'h0, 1'b1, 1'b0});
    vt.push_back('{"bne",   3'b010, 3'b001, 7'h00, 32'd9, 32'd9, 32'h0, 32'h0, 1'b0, 1'b0});
    vt.push_back('{"br010", 3'b010, 3'b010, 7'h00, 32'd3, 32'd3, 32'h0, 32'h0, 1'b0, 1'b1});
    vt.push_back('{"op111", 3'b111, 3'b000, 7'h00, 32'd3, 32'd4, 32'h0, 32'h0, 1'b0, 1'b1});
    vt.push_back('{"jal",   3'b011, 3'b000, 7'h00, 32'd3, 32'd4, 32'h100, 32'h104, 1'b0, 1'b0});
    vt.push_back('{"lui",   3'b110, 3'b000, 7'h00, 32'd3, 32'h1234_5000, 32'h0, 32'h1234_5000, 1'b0, 1'b0});
    vt.push_back('{"ldwrap",3'b100, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'd1, 1'b0, 1'b0});
    vt.push_back('{"store", 3'b101, 3'b010, 7'h00, 32'h1000, 32'h24, 32'h0, 32'h1024, 1'b0, 1'b0});
    vt.push_back('{"slt",   3'b000, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd1, 1'b0, 1'b0});
    vt.push_back('{"sltu",  3'b000, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd0, 1'b0, 1'b0});
    vt.push_back('{"sll",   3'b000, 3'b001, 7'h00, 32'd1, 32'h23, 32'h0, 32'd8, 1'b0, 1'b0});
    vt.push_back('{"sra_r", 3'b000, 3'b101, 7'h20, 32'hF000_0010, 32'd4, 32'h0, 32'hFF00_0001, 1'b0, 1'b0});
    vt.push_back('{"xor",   3'b000, 3'b100, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0FF0_0FF0, 1'b0, 1'b0});
    vt.push_back('{"or",    3'b000, 3'b110, 7'h00, 32'hF0F0_F0F0, 32'h0F00_0001, 32'h0, 32'hFFF0_F0F1, 1'b0, 1'b0});
    vt.push_back('{"and",   3'b000, 3'b111, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'hF000_F000, 1'b0, 1'b0});
    vt.push_back('{"add",   3'b000, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd3, 32'h0, 32'd2, 1'b0, 1'b0});

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(3'b000, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_taken", {31'b0, taken}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'b0, in_ready}, 32'd1);

    // Back-to-back stream, one op per cycle
    out_ready = 1'b1;
    n = vt.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(vt[i].op, vt[i].f3, vt[i].f7, vt[i].a, vt[i].b, vt[i].pc);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk({vt[i].nm, "_valid"}, {31'b0, out_valid}, 32'd1);
      chk({vt[i].nm, "_res"}, result, vt[i].res);
      chk({vt[i].nm, "_tk"}, {31'b0, taken}, {31'b0, vt[i].tk});
      chk({vt[i].nm, "_il"}, {31'b0, illegal}, {31'b0, vt[i].il});
      chk({vt[i].nm, "_ret"}, retired, 32'(i));
    end
    last = vt[n-1].res;

    // Back-pressure with a pending input
    @(negedge clk);
    out_ready = 1'b0;
    drive(3'b000, 3'b000, 7'h00, 32'd1, 32'd2, 32'h0);
    #1 chk("bp_ready", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result", result, last);
      chk("bp_retired", retired, 32'(n - 1));
      chk("bp_ready_hold", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("rel_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("rel_result", result, 32'd3);
    chk("rel_retired", retired, 32'(n));
    @(negedge clk);
    drive(3'b000, 3'b100, 7'h00, 32'hF, 32'h3, 32'h0);
    @(posedge clk);
    #1;
    chk("b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_result", result, 32'hC);
    chk("b2b_retired", retired, 32'(n + 1));
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_retired", retired, 32'(n + 2));

    // Flush a held JAL
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(3'b011, 3'b000, 7'h00, 32'h0, 32'h0, 32'h100);
    @(posedge clk);
    #1;
    chk("jal_valid", {31'b0, out_valid}, 32'd1);
    chk("jal_result", result, 32'h104);
    @(negedge clk);
    flush = 1'b1;
    drive(3'b000, 3'b000, 7'h00, 32'd4, 32'd4, 32'h0);
    #1 chk("flush_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_retired", retired, 32'(n + 2));
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Counter wrap from a preloaded all-ones value
    force dut.retired_o = 32'hFFFF_FFFF;
    #1 release dut.retired_o;
    #1 chk("wrap_preload", retired, 32'hFFFF_FFFF);
    drive(3'b000, 3'b000, 7'h00, 32'd1, 32'd1, 32'h0);
    in_valid = 1'b1;
    @(posedge clk);
    #1 chk("wrap_accept", result, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap_retired", retired, 32'd0);
    chk("wrap_valid", {31'b0, out_valid}, 32'd0);

    // Reset while stalled
    @(negedge clk);
    drive(3'b000, 3'b000, 7'h20, 32'd5, 32'd7, 32'h0);
    in_valid = 1'b1;
    @(negedge clk);
    drive(3'b010, 3'b000, 7'h00, 32'd6, 32'd6, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_retired", retired, 32'd1);
    chk("stall_taken", {31'b0, taken}, 32'd1);
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b1;
    in_valid = 1'b1;
    drive(3'b011, 3'b000, 7'h00, 32'h0, 32'h0, 32'h200);
    @(posedge clk);
    #1;
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_taken", {31'b0, taken}, 32'd0);
    chk("mrst_illegal", {31'b0, illegal}, 32'd0);
    chk("mrst_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    #1 chk("mrst_ready", {31'b0, in_ready}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
